// File: rtl/text_pkg.sv
// Shared definitions for the attributed text-mode pixel pipeline.
//   PALETTE     : 16-entry RGB565 palette, CGA order (0 black .. 15 white)
//   pal_lookup  : palette index -> RGB565
//   FG_LSB/BG_LSB : nibble positions of fg/bg inside the attribute byte
//   RENDER_LAT  : clocks from raster inputs to o_* (use it to align overlays)
package text_pkg;

  localparam int RENDER_LAT = 3;

  localparam int FG_LSB = 0;
  localparam int BG_LSB = 4;

  // Entry 15 first: packed array, index [i] selects palette entry i.
  localparam logic [15:0][15:0] PALETTE = {
    16'hFFFF, 16'hFFEA, 16'hFABF, 16'hFAAA,  // 15 white, 14 yellow, 13 lt magenta, 12 lt red
    16'h57FF, 16'h57EA, 16'h52BF, 16'h52AA,  // 11 lt cyan, 10 lt green, 9 lt blue, 8 dk grey
    16'hAD55, 16'hAAA0, 16'hA815, 16'hA800,  //  7 lt grey, 6 brown, 5 magenta, 4 red
    16'h0555, 16'h0540, 16'h0015, 16'h0000   //  3 cyan, 2 green, 1 blue, 0 black
  };

  function automatic logic [15:0] pal_lookup(input logic [3:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/cursor_blink.sv
// Frame-rate cursor state: vsync rising-edge detect, blink counter/phase and
// the per-frame cursor latch (so the cursor never tears mid-frame).
//   clk, rst          : pixel clock, async active-high reset
//   vsync             : on-time vertical sync
//   cur_x/cur_y/cur_en: live cursor position/enable
//   lat_x/lat_y       : cursor position latched at the last frame edge
//   cursor_on         : latched enable AND blink phase
module cursor_blink #(
  parameter int COLS_LOG2    = 6,
  parameter int ROWS_LOG2    = 6,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vsync,
  input  logic [COLS_LOG2-1:0] cur_x,
  input  logic [ROWS_LOG2-1:0] cur_y,
  input  logic                 cur_en,
  output logic [COLS_LOG2-1:0] lat_x,
  output logic [ROWS_LOG2-1:0] lat_y,
  output logic                 cursor_on
);

  localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);

  logic       vs_d;
  logic [7:0] cnt;
  logic       phase;
  logic       lat_en;
  logic       frame_edge;

  assign frame_edge = vsync & ~vs_d;
  assign cursor_on  = lat_en & phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d   <= 1'b0;
      cnt    <= '0;
      phase  <= 1'b1;
      lat_en <= 1'b0;
      lat_x  <= '0;
      lat_y  <= '0;
    end else begin
      vs_d <= vsync;
      if (frame_edge) begin
        lat_x  <= cur_x;
        lat_y  <= cur_y;
        lat_en <= cur_en;
        // Counter runs whether or not the cursor is enabled.
        if (cnt == LAST) begin
          cnt   <= '0;
          phase <= ~phase;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/text_render_attr.sv
// Attributed text-mode pixel pipeline: raster position -> char buffer and
// font ROM addresses -> RGB565 with aligned syncs, 3 clocks end to end.
//   i_x/i_y/i_hsync/i_vsync/i_de : on-time raster timing
//   o_vram_addr / i_vram_data    : {row,col} -> {attr,char}, 1 clk read
//   o_font_addr / i_font_row     : {char,glyph row} -> row bits, 1 clk read
//   i_cursor_*                   : cursor, sampled at each vsync rising edge
//   o_r/o_g/o_b/o_hsync/o_vsync/o_de : delayed outputs
module text_render_attr
  import text_pkg::*;
#(
  parameter int FONT_W       = 8,
  parameter int FONT_H       = 8,
  parameter int COLS_LOG2    = 6,
  parameter int ROWS_LOG2    = 6,
  parameter int X_W          = 9,
  parameter int Y_W          = 9,
  parameter int ATTR_EN      = 1,
  parameter int BLINK_FRAMES = 30,
  parameter int CURSOR_ROWS  = 2
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [X_W-1:0]                    i_x,
  input  logic [Y_W-1:0]                    i_y,
  input  logic                              i_hsync,
  input  logic                              i_vsync,
  input  logic                              i_de,
  output logic [ROWS_LOG2+COLS_LOG2-1:0]    o_vram_addr,
  input  logic [15:0]                       i_vram_data,
  output logic [8+$clog2(FONT_H)-1:0]       o_font_addr,
  input  logic [FONT_W-1:0]                 i_font_row,
  input  logic [COLS_LOG2-1:0]              i_cursor_x,
  input  logic [ROWS_LOG2-1:0]              i_cursor_y,
  input  logic                              i_cursor_en,
  output logic [4:0]                        o_r,
  output logic [5:0]                        o_g,
  output logic [4:0]                        o_b,
  output logic                              o_hsync,
  output logic                              o_vsync,
  output logic                              o_de
);

  localparam int FX = $clog2(FONT_W);
  localparam int FY = $clog2(FONT_H);
  localparam logic [FY-1:0] CUR_Y0 = FY'(FONT_H - CURSOR_ROWS);

  // S1 / S2 state
  logic [FX-1:0]        xc_s1, xc_s2;
  logic [FY-1:0]        yc_s1, yc_s2;
  logic [COLS_LOG2-1:0] col_s1, col_s2;
  logic [ROWS_LOG2-1:0] row_s1, row_s2;
  logic [7:0]           attr_s2;

  // de/sync delay lines; bit n is the value after stage n
  logic [RENDER_LAT:1]  vld_pipe, hs_pipe, vs_pipe;

  logic [COLS_LOG2-1:0] cur_col;
  logic [ROWS_LOG2-1:0] cur_row;
  logic                 cur_on;

  logic [3:0]           fg_idx, bg_idx;
  logic                 in_cursor, pix_fg;
  logic [15:0]          rgb_s2;

  // Upper raster bits are dropped, so the grid wraps.
  assign o_vram_addr = {i_y[FY +: ROWS_LOG2], i_x[FX +: COLS_LOG2]};
  assign o_font_addr = {i_vram_data[7:0], yc_s1};

  assign o_de    = vld_pipe[RENDER_LAT];
  assign o_hsync = hs_pipe[RENDER_LAT];
  assign o_vsync = vs_pipe[RENDER_LAT];

  cursor_blink #(
    .COLS_LOG2   (COLS_LOG2),
    .ROWS_LOG2   (ROWS_LOG2),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk      (i_clk),
    .rst      (i_rst),
    .vsync    (i_vsync),
    .cur_x    (i_cursor_x),
    .cur_y    (i_cursor_y),
    .cur_en   (i_cursor_en),
    .lat_x    (cur_col),
    .lat_y    (cur_row),
    .cursor_on(cur_on)
  );

  always_comb begin
    fg_idx = 4'hF;
    bg_idx = 4'h0;
    if (ATTR_EN != 0) begin
      fg_idx = attr_s2[FG_LSB +: 4];
      bg_idx = attr_s2[BG_LSB +: 4];
    end
    in_cursor = cur_on && (col_s2 == cur_col) && (row_s2 == cur_row) &&
                (yc_s2 >= CUR_Y0);
    // FONT_W is a power of two, so FONT_W-1-xc is just ~xc.
    pix_fg = i_font_row[~xc_s2] | in_cursor;
    rgb_s2 = '0;
    if (vld_pipe[2])
      rgb_s2 = pix_fg ? pal_lookup(fg_idx) : pal_lookup(bg_idx);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      xc_s1    <= '0;
      yc_s1    <= '0;
      col_s1   <= '0;
      row_s1   <= '0;
      xc_s2    <= '0;
      yc_s2    <= '0;
      col_s2   <= '0;
      row_s2   <= '0;
      attr_s2  <= '0;
      vld_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      o_r      <= '0;
      o_g      <= '0;
      o_b      <= '0;
    end else begin
      xc_s1    <= i_x[FX-1:0];
      yc_s1    <= i_y[FY-1:0];
      col_s1   <= i_x[FX +: COLS_LOG2];
      row_s1   <= i_y[FY +: ROWS_LOG2];
      xc_s2    <= xc_s1;
      yc_s2    <= yc_s1;
      col_s2   <= col_s1;
      row_s2   <= row_s1;
      attr_s2  <= i_vram_data[15:8];
      vld_pipe <= {vld_pipe[RENDER_LAT-1:1], i_de};
      hs_pipe  <= {hs_pipe[RENDER_LAT-1:1], i_hsync};
      vs_pipe  <= {vs_pipe[RENDER_LAT-1:1], i_vsync};
      {o_r, o_g, o_b} <= rgb_s2;
    end
  end

endmodule
